stack_op_sequencer: RTL and testbench

//  Executes CALL/RET stack traffic while cpu_control sits in its stack-op state.
//  - CALL: pushes the 2-byte return PC to the data memory stack, then pulses branch to the call target.
//  - RET: pops 2 bytes and pulses branch to the popped PC.

---
 rtl/stack_op_sequencer.sv | 140 ++++++++++++++
 tb/tb_stack_op_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/stack_op_sequencer.sv
// CALL/RET stack sequencer: pushes/pops a 2-byte PC over the shared data-memory port, then pulses branch.
// Optional depth guard enabled by defining STACK_GUARD_EN (default build: no guard, stack_err tied 0).
module stack_op_sequencer #(
    parameter int                PC_W        = 16,
    parameter int                ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] STACK_TOP   = ADDR_W'(16'hFFFF),
    parameter int                STACK_DEPTH = 64
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              call_req,
    input  logic              ret_req,
    input  logic [PC_W-1:0]   ret_pc,
    input  logic [PC_W-1:0]   call_target,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack,
    output logic              branch,
    output logic [PC_W-1:0]   branch_target,
    output logic              busy,
    output logic [ADDR_W-1:0] sp,
    output logic              stack_err
);

    typedef enum logic [2:0] {
        IDLE, PUSH_HI, PUSH_LO, POP_LO, POP_HI, BRANCH, ERR
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] depth;
    logic [PC_W-1:0]   ret_pc_q;
    logic [PC_W-1:0]   tgt_q;
    logic [7:0]        lo_q;
    logic [15:0]       pc16;
    logic              call_blocked;
    logic              ret_blocked;

    assign pc16 = 16'(ret_pc_q);

`ifdef STACK_GUARD_EN
    localparam logic [ADDR_W-1:0] CALL_LIMIT = ADDR_W'(STACK_DEPTH - 2);
    assign call_blocked = depth > CALL_LIMIT;
    assign ret_blocked  = depth < ADDR_W'(2);
    assign stack_err    = (state == ERR);
`else
    assign call_blocked = 1'b0;
    assign ret_blocked  = 1'b0;
    assign stack_err    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_) state <= IDLE;
        else         state <= state_nxt;
    end

    // SP and depth move once per acknowledged byte; wrap is modulo 2^ADDR_W.
    always_ff @(posedge clk) begin
        if (!reset_) begin
            sp    <= STACK_TOP;
            depth <= '0;
        end else if (mem_ack) begin
            case (state)
                PUSH_HI, PUSH_LO: begin
                    sp    <= sp - ADDR_W'(1);
                    depth <= depth + ADDR_W'(1);
                end
                POP_LO, POP_HI: begin
                    sp    <= sp + ADDR_W'(1);
                    depth <= depth - ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Operand/target holding registers carry data only and need no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && call_req) begin
            ret_pc_q <= ret_pc;
            tgt_q    <= call_target;
        end
        if (state == POP_LO && mem_ack) lo_q <= mem_rdata;
        if (state == POP_HI && mem_ack) tgt_q <= PC_W'({mem_rdata, lo_q});
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (call_req)     state_nxt = call_blocked ? ERR : PUSH_HI;
                else if (ret_req) state_nxt = ret_blocked  ? ERR : POP_LO;
            end
            PUSH_HI: if (mem_ack) state_nxt = PUSH_LO;
            PUSH_LO: if (mem_ack) state_nxt = BRANCH;
            POP_LO:  if (mem_ack) state_nxt = POP_HI;
            POP_HI:  if (mem_ack) state_nxt = BRANCH;
            BRANCH:  state_nxt = IDLE;
            default: state_nxt = state;
        endcase
    end

    // Outputs decode from state only, so they hold stable across wait cycles.
    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        branch        = 1'b0;
        branch_target = '0;
        case (state)
            PUSH_HI: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = sp;
                mem_wdata = pc16[15:8];
            end
            PUSH_LO: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = sp;
                mem_wdata = pc16[7:0];
            end
            POP_LO, POP_HI: begin
                mem_req  = 1'b1;
                mem_addr = sp + ADDR_W'(1);
            end
            BRANCH: begin
                branch        = 1'b1;
                branch_target = tgt_q;
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Scoreboard bench for stack_op_sequencer: stimulus queues expected accesses/branches, a monitor checks them.
module tb_stack_op_sequencer;

    logic        clk = 1'b0;
    logic        reset_ = 1'b0;
    logic        call_req = 1'b0;
    logic        ret_req = 1'b0;
    logic [15:0] ret_pc = '0;
    logic [15:0] call_target = '0;
    logic        mem_req, mem_we, mem_ack;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        branch, busy, stack_err;
    logic [15:0] branch_target, sp;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          ack_delay = 0;
    int          wcnt = 0;
    logic        ack_force = 1'b0;
    logic [7:0]  mem [0:65535];
    logic [15:0] sp_model = 16'hFFFF;

    typedef struct {logic we; logic [15:0] addr; logic [7:0] wdata;} acc_t;
    typedef struct {logic [15:0] tgt; int at;} br_t;
    acc_t acc_q[$];
    br_t  br_q[$];

    stack_op_sequencer dut (
        .clk(clk), .reset_(reset_), .call_req(call_req), .ret_req(ret_req),
        .ret_pc(ret_pc), .call_target(call_target), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .branch(branch), .branch_target(branch_target), .busy(busy), .sp(sp),
        .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    // Memory model with programmable wait states per access.
    assign mem_ack   = (mem_req && (wcnt == ack_delay)) || ack_force;
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_req && mem_ack) begin
            wcnt <= 0;
            if (mem_we) mem[mem_addr] <= mem_wdata;
        end else if (mem_req) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: handshake stability, access order and branch timing.
    logic        prev_wait = 1'b0;
    logic [15:0] prev_addr;
    logic        prev_we;
    logic [7:0]  prev_wdata;
    acc_t        a;
    br_t         b;

    always @(negedge clk) begin
        if (mem_req && prev_wait) begin
            chk("hold_addr", 32'(mem_addr), 32'(prev_addr));
            chk("hold_we", 32'(mem_we), 32'(prev_we));
            if (mem_we) chk("hold_wdata", 32'(mem_wdata), 32'(prev_wdata));
        end
        prev_wait  = mem_req && !mem_ack;
        prev_addr  = mem_addr;
        prev_we    = mem_we;
        prev_wdata = mem_wdata;
        if (mem_req && mem_ack) begin
            if (acc_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_access we=%b addr=%h (no access expected)", mem_we, mem_addr);
            end else begin
                a = acc_q.pop_front();
                chk("acc_we", 32'(mem_we), 32'(a.we));
                chk("acc_addr", 32'(mem_addr), 32'(a.addr));
                if (a.we) chk("acc_wdata", 32'(mem_wdata), 32'(a.wdata));
            end
        end
        if (branch) begin
            if (br_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_branch target=%h (no branch expected)", branch_target);
            end else begin
                b = br_q.pop_front();
                chk("branch_target", 32'(branch_target), 32'(b.tgt));
                chk("branch_cycle", 32'(cyc), 32'(b.at));
            end
        end
    end

    task automatic issue(input logic c, input logic r, input logic [15:0] rp,
                         input logic [15:0] ct, input int dly);
        ack_delay   = dly;
        call_req    = c;
        ret_req     = r;
        ret_pc      = rp;
        call_target = ct;
        @(negedge clk);
        call_req    = 1'b0;
        ret_req     = 1'b0;
        ret_pc      = 16'hDEAD;
        call_target = 16'hBEEF;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout_busy", 32'(busy), 32'd0);
    endtask

    task automatic do_call(input logic [15:0] rp, input logic [15:0] ct, input int dly,
                           input logic also_ret);
        acc_q.push_back('{1'b1, sp_model, rp[15:8]});
        acc_q.push_back('{1'b1, sp_model - 16'd1, rp[7:0]});
        br_q.push_back('{ct, cyc + 3 + 2 * dly});
        issue(1'b1, also_ret, rp, ct, dly);
        wait_idle();
        sp_model = sp_model - 16'd2;
        chk("sp_after_call", 32'(sp), 32'(sp_model));
    endtask

    task automatic do_ret(input logic [15:0] exp_pc, input int dly);
        acc_q.push_back('{1'b0, sp_model + 16'd1, 8'h00});
        acc_q.push_back('{1'b0, sp_model + 16'd2, 8'h00});
        br_q.push_back('{exp_pc, cyc + 3 + 2 * dly});
        issue(1'b0, 1'b1, 16'h0, 16'h0, dly);
        wait_idle();
        sp_model = sp_model + 16'd2;
        chk("sp_after_ret", 32'(sp), 32'(sp_model));
    endtask

    task automatic pulse_reset();
        reset_ = 1'b0;
        repeat (2) @(negedge clk);
        reset_ = 1'b1;
        sp_model = 16'hFFFF;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired cyc=%0d required=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_branch", 32'(branch), 32'd0);
        chk("rst_sp", 32'(sp), 32'hFFFF);
        chk("rst_stack_err", 32'(stack_err), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        reset_ = 1'b1;
        @(negedge clk);

        do_call(16'h1234, 16'h0400, 0, 1'b0);
        chk("mem_FFFF", 32'(mem[16'hFFFF]), 32'h12);
        chk("mem_FFFE", 32'(mem[16'hFFFE]), 32'h34);
        do_ret(16'h1234, 0);

        do_call(16'hABCD, 16'h0BEE, 2, 1'b0);
        do_call(16'h5678, 16'h1111, 1, 1'b0);
        do_ret(16'h5678, 1);
        do_ret(16'hABCD, 0);

        do_call(16'h0F0F, 16'h2222, 0, 1'b1);
        do_ret(16'h0F0F, 0);

        ack_force = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_ack_sp", 32'(sp), 32'hFFFF);
        chk("idle_ack_busy", 32'(busy), 32'd0);
        ack_force = 1'b0;

        acc_q.push_back('{1'b1, 16'hFFFF, 8'h9A});
        acc_q.push_back('{1'b1, 16'hFFFE, 8'hBC});
        issue(1'b1, 1'b0, 16'h9ABC, 16'h3333, 0);
        @(negedge clk);
        chk("pushlo_addr", 32'(mem_addr), 32'hFFFE);
        reset_ = 1'b0;
        @(negedge clk);
        chk("abort_mem_req", 32'(mem_req), 32'd0);
        chk("abort_sp", 32'(sp), 32'hFFFF);
        chk("abort_busy", 32'(busy), 32'd0);
        reset_ = 1'b1;
        sp_model = 16'hFFFF;
        repeat (4) @(negedge clk);

`ifdef STACK_GUARD_EN
        issue(1'b0, 1'b1, 16'h0, 16'h0, 0);
        @(negedge clk);
        chk("guard_ret_err", 32'(stack_err), 32'd1);
        chk("guard_ret_busy", 32'(busy), 32'd1);
        chk("guard_ret_req", 32'(mem_req), 32'd0);
        pulse_reset();
        for (int i = 0; i < 32; i++) do_call(16'h1000 + 16'(i), 16'h2000 + 16'(i), 0, 1'b0);
        chk("guard_32_err", 32'(stack_err), 32'd0);
        issue(1'b1, 1'b0, 16'h7777, 16'h8888, 0);
        @(negedge clk);
        chk("guard_33_err", 32'(stack_err), 32'd1);
        chk("guard_33_req", 32'(mem_req), 32'd0);
        chk("guard_33_sp", 32'(sp), 32'hFFBF);
        pulse_reset();
`else
        pulse_reset();
        chk("noguard_err", 32'(stack_err), 32'd0);
`endif

        repeat (2) @(negedge clk);
        chk("acc_q_drained", 32'(acc_q.size()), 32'd0);
        chk("br_q_drained", 32'(br_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
